// File: rtl/spi_frame_loader.sv
// SPI mode-0 slave that unpacks 12-bit channel values (two channels per three bytes)
// into framebuffer writes and reports each transaction as a complete frame or an error.
`timescale 1ns/1ps
module spi_frame_loader #(
   parameter int unsigned c_ledboards = 30,
   parameter int unsigned c_bpc       = 12,
   parameter int unsigned c_addr_w    = $clog2(c_ledboards*32)
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_sck,
   input  logic                i_csn,
   input  logic                i_mosi,
   output logic                o_wen,
   output logic [c_addr_w-1:0] o_waddr,
   output logic [c_bpc-1:0]    o_wdata,
   output logic                o_frame_done,
   output logic                o_err,
   output logic                o_busy
);

   localparam int unsigned c_channels = c_ledboards*32;
   localparam logic [c_addr_w:0] cnt_full = (c_addr_w+1)'(c_channels);

   typedef enum logic [1:0] {IDLE, CMD, DATA, DRAIN} state_t;

   logic [1:0] sck_s, csn_s, mosi_s, valid;
   logic       sck_prev, csn_prev, sck_rise, csn_fall, csn_rise, mosi_q, armed;

   state_t        state;
   logic [2:0]    bitcnt;
   logic [6:0]    shift;
   logic [1:0]    phase;
   logic [7:0]    b0;
   logic [3:0]    nib;
   logic [c_addr_w:0] cnt;
   logic          bad, ovf;

   logic [7:0]        byte_next;
   logic [c_addr_w:0] cnt_nxt;

   assign byte_next = {shift, mosi_q};
   assign cnt_nxt   = cnt + 1'b1;

   // valid marks when csn_s[1] holds a real pin sample rather than its reset value,
   // so CSn held low through reset never arms the receiver.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sck_s    <= 2'b00;
         csn_s    <= 2'b11;
         mosi_s   <= 2'b00;
         valid    <= 2'b00;
         sck_prev <= 1'b0;
         csn_prev <= 1'b1;
         sck_rise <= 1'b0;
         csn_fall <= 1'b0;
         csn_rise <= 1'b0;
         mosi_q   <= 1'b0;
         armed    <= 1'b0;
      end else begin
         sck_s    <= {sck_s[0], i_sck};
         csn_s    <= {csn_s[0], i_csn};
         mosi_s   <= {mosi_s[0], i_mosi};
         valid    <= {valid[0], 1'b1};
         sck_prev <= sck_s[1];
         csn_prev <= csn_s[1];
         sck_rise <= sck_s[1] & ~sck_prev;
         csn_fall <= ~csn_s[1] & csn_prev;
         csn_rise <= csn_s[1] & ~csn_prev;
         mosi_q   <= mosi_s[1];
         if (valid[1] && csn_s[1])
            armed <= 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         bitcnt       <= '0;
         shift        <= '0;
         phase        <= '0;
         b0           <= '0;
         nib          <= '0;
         cnt          <= '0;
         bad          <= 1'b0;
         ovf          <= 1'b0;
         o_wen        <= 1'b0;
         o_waddr      <= '0;
         o_wdata      <= '0;
         o_frame_done <= 1'b0;
         o_err        <= 1'b0;
         o_busy       <= 1'b0;
      end else begin
         o_wen        <= 1'b0;
         o_frame_done <= 1'b0;
         o_err        <= 1'b0;
         if (state == IDLE) begin
            if (csn_fall && armed) begin
               state  <= CMD;
               o_busy <= 1'b1;
               bitcnt <= '0;
               phase  <= '0;
               cnt    <= '0;
               bad    <= 1'b0;
               ovf    <= 1'b0;
            end
         end else if (csn_rise) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            bitcnt <= '0;
            phase  <= '0;
            bad    <= 1'b0;
            ovf    <= 1'b0;
            if (cnt == cnt_full && !bad && !ovf)
               o_frame_done <= 1'b1;
            else
               o_err <= 1'b1;
         end else if (sck_rise) begin
            shift  <= byte_next[6:0];
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
               case (state)
                  CMD: begin
                     if (byte_next == 8'h01) begin
                        state <= DATA;
                        cnt   <= '0;
                     end else begin
                        state <= DRAIN;
                        bad   <= 1'b1;
                     end
                  end
                  DATA: begin
                     case (phase)
                        2'd0: begin
                           b0    <= byte_next;
                           phase <= 2'd1;
                        end
                        2'd1: begin
                           o_wen   <= 1'b1;
                           o_waddr <= cnt[c_addr_w-1:0];
                           o_wdata <= {b0, byte_next[7:4]};
                           nib     <= byte_next[3:0];
                           cnt     <= cnt_nxt;
                           phase   <= 2'd2;
                           if (cnt_nxt == cnt_full)
                              state <= DRAIN;
                        end
                        default: begin
                           o_wen   <= 1'b1;
                           o_waddr <= cnt[c_addr_w-1:0];
                           o_wdata <= {nib, byte_next};
                           cnt     <= cnt_nxt;
                           phase   <= 2'd0;
                           if (cnt_nxt == cnt_full)
                              state <= DRAIN;
                        end
                     endcase
                  end
                  default: ovf <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Upstream feeder for the target framebuffer: an SPI slave (mode 0, MSB first) that receives a full frame of 12-bit channel values from the host MCU and writes them through the framebuffer write port (i_wen/i_waddr/i_wdata). Runs in the divided system clock domain and samples the asynchronous SPI pins with synchronizers. Signals a completed, well-formed frame with a one-cycle pulse and flags malformed transactions.

## Interface

- c_ledboards, 30, number of LED boards; c_channels = c_ledboards*32
- c_bpc, 12, bits per channel; fixed at 12 (byte packing below depends on it)
- c_addr_w, $clog2(c_ledboards*32), framebuffer address width
- i_clk  in  1  system clock (divided clock, same as framebuffers)
- i_rst_n  in  1  reset, asynchronous, active-low
- i_sck  in  1  SPI clock, asynchronous, idle low
- i_csn  in  1  SPI chip select, asynchronous, active-low
- i_mosi  in  1  SPI data, valid on SCK rising edge
- o_wen  out  1  framebuffer write enable, one-cycle pulse per channel
- o_waddr  out  c_addr_w  framebuffer write address
- o_wdata  out  c_bpc  framebuffer write data
- o_frame_done  out  1  one-cycle pulse: transaction ended with exactly c_channels writes
- o_err  out  1  one-cycle pulse: transaction ended malformed
- o_busy  out  1  high while a transaction is in progress (state != IDLE)

## Operation

- i_sck, i_csn, i_mosi each pass a 2-FF synchronizer (reset value: sck 0, csn 1, mosi 0), then one edge-detect register. SCK rising edge samples mosi into an 8-bit shift register; bit counter 0..7.
- Arming: after reset, a CSn falling edge is only accepted once synchronized CSn has been seen high for ≥1 cycle (armed flag). CSn low out of reset is ignored until it rises.
- States: IDLE -> (CSn fall, armed) CMD -> DATA or DRAIN; any state -> IDLE on CSn rise.
- CMD: first byte. 0x01 -> DATA, address/channel count cleared to 0. Any other value -> DRAIN with bad-cmd flag set.
- DATA: bytes grouped in threes (b0,b1,b2) packing two channels: even = {b0, b1[7:4]}, odd = {b1[3:0], b2}. Even channel written on completion of b1, odd on completion of b2. Address increments by 1 after each write.
- Channel count (c_addr_w+1 bits) reaches c_channels -> DRAIN; further bytes ignored; any further completed byte sets overflow flag.
- DRAIN: shift bytes, write nothing, until CSn rise.
- CSn rise: partial byte discarded. If count == c_channels and no bad-cmd/overflow flag -> o_frame_done; else (short frame, bad cmd, overflow, CSn rise in CMD) -> o_err. Exactly one of the two pulses per accepted transaction. Flags, bit counter, group phase cleared.
- Writes already performed for a short/bad frame are not undone; host must resend.

## Timing

- Reset: o_wen=0, o_waddr=0, o_wdata=0, o_frame_done=0, o_err=0, o_busy=0, state IDLE, armed=0.
- Requirement: f_sck ≤ f_clk/4; SCK high and low each ≥2 i_clk cycles; CSn setup to first SCK rise and hold after last SCK fall ≥3 i_clk cycles.
- Latency: o_wen asserted 4 i_clk cycles after the i_sck rising edge completing the byte (2 sync + 1 edge detect + 1 output register). o_wen/o_waddr/o_wdata change together; o_waddr/o_wdata hold after o_wen drops.
- o_frame_done/o_err: 4 cycles after i_csn rising edge. o_busy rises 4 cycles after i_csn fall, falls with the done/err pulse.
- Writes never coincide; minimum spacing between o_wen pulses is 8 SCK periods.
- Address wrap impossible: writing stops at c_channels-1.

## Test plan

- Full frame: CSn low, 0x01, 1440 bytes (channel n = n & 0xFFF) -> 960 o_wen pulses, addr 0..959, data n&0xFFF; one o_frame_done, no o_err.
- Packing: 0x01, bytes 0xAB 0xCD 0xEF -> writes addr0=0xABC, addr1=0xDEF, o_wen 4 cycles after byte-completing SCK edge; CSn rise -> o_err (short).
- Bad command: 0x55 then 6 bytes -> no o_wen; o_err on CSn rise.
- Overflow: full frame plus 1 extra byte -> 960 writes only, o_err, no o_frame_done.
- CSn abort mid-byte after 5 bits of b1 -> no write for that group; o_err; next transaction 0x01 restarts at addr 0.
- Reset with CSn held low, release, continue clocking -> no writes/pulses until CSn rises and falls again; asynchronous reset mid-frame -> all outputs 0 immediately.
